// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key schedule: one 32-bit word per clock into a round-key store,
// registered 128-bit round-key read port. Define AES_KS_INV_EN for equivalent-inverse-cipher keys.
module aes_key_schedule_seq #(
   parameter int KEY_BITS = 128,
   parameter int RK_AW    = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [KEY_BITS-1:0] key_in,
   input  logic                key_valid,
   output logic                key_ready,
   output logic                ks_busy,
   output logic                ks_done,
   input  logic [RK_AW-1:0]    rk_round,
   input  logic                rk_inv,
   output logic [127:0]        rk_data
);

   localparam int NK    = KEY_BITS / 32;
   localparam int NR    = NK + 6;
   localparam int TOTAL = 4 * (NR + 1);
   localparam int IW    = $clog2(TOTAL);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_GEN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   generate
      if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
         $error("aes_key_schedule_seq: KEY_BITS must be 128, 192 or 256");
      end
      if ((2 ** RK_AW) <= NR) begin : g_bad_rk_aw
         $error("aes_key_schedule_seq: RK_AW too narrow for NR");
      end
   endgenerate

   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TBL[2047 - 8 * int'(x) -: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

`ifdef AES_KS_INV_EN
   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a    [4];
      logic [7:0] m9   [4];
      logic [7:0] m11  [4];
      logic [7:0] m13  [4];
      logic [7:0] m14  [4];
      logic [7:0] m2, m4, m8;
      for (int k = 0; k < 4; k++) begin
         a[k]   = c[31-8*k -: 8];
         m2     = xtime(a[k]);
         m4     = xtime(m2);
         m8     = xtime(m4);
         m9[k]  = m8 ^ a[k];
         m11[k] = m8 ^ m2 ^ a[k];
         m13[k] = m8 ^ m4 ^ a[k];
         m14[k] = m8 ^ m4 ^ m2;
      end
      return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
              m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
              m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
              m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
   endfunction
`endif

   logic [1:0]     state_q, state_d;
   logic [IW-1:0]  i_q, i_d;
   logic [2:0]     phase_q, phase_d;
   logic [7:0]     rcon_q, rcon_d;
   logic           done_q, done_d;
   logic [31:0]    hist_q [NK];
   logic [31:0]    hist_d [NK];
   logic [31:0]    store_q [TOTAL];
   logic [127:0]   rk_data_q, rk_data_d;

   logic           accept;
   logic [31:0]    t_prev, sub_in, sub_out, t_mix, new_word;
   logic           rd_ok;
   logic [IW-1:0]  rd_base;
   logic [127:0]   rd_word;

   assign key_ready = (state_q != ST_GEN);
   assign ks_busy   = (state_q == ST_GEN);
   assign ks_done   = done_q;
   assign rk_data   = rk_data_q;
   assign accept    = key_valid && key_ready;

   // hist_q[NK-1] is w[i-1], hist_q[0] is w[i-NK]; the single SubWord serves both substitution cases.
   always_comb begin
      t_prev   = hist_q[NK-1];
      sub_in   = (phase_q == 3'd0) ? {t_prev[23:0], t_prev[31:24]} : t_prev;
      sub_out  = sub_word(sub_in);
      if (phase_q == 3'd0) begin
         t_mix = sub_out ^ {rcon_q, 24'h0};
      end else if (NK == 8 && phase_q == 3'd4) begin
         t_mix = sub_out;
      end else begin
         t_mix = t_prev;
      end
      new_word = hist_q[0] ^ t_mix;
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      phase_d = phase_q;
      rcon_d  = rcon_q;
      done_d  = done_q;
      hist_d  = hist_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               for (int k = 0; k < NK; k++) begin
                  hist_d[k] = key_in[KEY_BITS-1-32*k -: 32];
               end
               state_d = ST_GEN;
               i_d     = IW'(NK);
               phase_d = 3'd0;
               rcon_d  = 8'h01;
               done_d  = 1'b0;
            end
         end
         ST_GEN: begin
            for (int k = 0; k < NK - 1; k++) begin
               hist_d[k] = hist_q[k+1];
            end
            hist_d[NK-1] = new_word;
            i_d          = i_q + IW'(1);
            phase_d      = (phase_q == 3'(NK - 1)) ? 3'd0 : phase_q + 3'd1;
            if (phase_q == 3'd0) begin
               rcon_d = xtime(rcon_q);
            end
            if (i_q == IW'(TOTAL - 1)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Reads are gated off on the accept edge so a new key never exposes a half-overwritten store.
   always_comb begin
      rd_ok   = done_q && !accept && (rk_round <= RK_AW'(NR));
      rd_base = rd_ok ? IW'({rk_round, 2'b00}) : '0;
      rd_word = {store_q[rd_base],
                 store_q[rd_base | IW'(1)],
                 store_q[rd_base | IW'(2)],
                 store_q[rd_base | IW'(3)]};
`ifdef AES_KS_INV_EN
      if (rk_inv && rk_round != '0 && rk_round < RK_AW'(NR)) begin
         rd_word = {inv_mix_col(rd_word[127:96]), inv_mix_col(rd_word[95:64]),
                    inv_mix_col(rd_word[63:32]),  inv_mix_col(rd_word[31:0])};
      end
`endif
      rk_data_d = rd_ok ? rd_word : '0;
   end

`ifndef AES_KS_INV_EN
   logic unused_rk_inv;
   assign unused_rk_inv = rk_inv;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         i_q       <= '0;
         phase_q   <= 3'd0;
         rcon_q    <= 8'h01;
         done_q    <= 1'b0;
         rk_data_q <= '0;
         for (int k = 0; k < NK; k++) begin
            hist_q[k] <= '0;
         end
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         phase_q   <= phase_d;
         rcon_q    <= rcon_d;
         done_q    <= done_d;
         rk_data_q <= rk_data_d;
         hist_q    <= hist_d;
      end
   end

   // The store holds no reset: it is only meaningful once ks_done is set.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < NK; k++) begin
            store_q[IW'(k)] <= key_in[KEY_BITS-1-32*k -: 32];
         end
      end else if (state_q == ST_GEN) begin
         store_q[i_q] <= new_word;
      end
   end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed bench for aes_key_schedule_seq: one instance per key size, FIPS-197 vectors,
// handshake, mid-expansion reset and (with AES_KS_INV_EN) inverse-form round keys.
module tb_aes_key_schedule_seq;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [255:0] key       [3];
   logic         key_valid [3];
   logic         key_ready [3];
   logic         ks_busy   [3];
   logic         ks_done   [3];
   logic [3:0]   rk_round  [3];
   logic         rk_inv;
   logic [127:0] rk_data   [3];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   aes_key_schedule_seq #(.KEY_BITS(128), .RK_AW(4)) u_dut128 (
      .clk(clk), .rst_n(rst_n), .key_in(key[0][127:0]), .key_valid(key_valid[0]),
      .key_ready(key_ready[0]), .ks_busy(ks_busy[0]), .ks_done(ks_done[0]),
      .rk_round(rk_round[0]), .rk_inv(rk_inv), .rk_data(rk_data[0]));

   aes_key_schedule_seq #(.KEY_BITS(192), .RK_AW(4)) u_dut192 (
      .clk(clk), .rst_n(rst_n), .key_in(key[1][191:0]), .key_valid(key_valid[1]),
      .key_ready(key_ready[1]), .ks_busy(ks_busy[1]), .ks_done(ks_done[1]),
      .rk_round(rk_round[1]), .rk_inv(rk_inv), .rk_data(rk_data[1]));

   aes_key_schedule_seq #(.KEY_BITS(256), .RK_AW(4)) u_dut256 (
      .clk(clk), .rst_n(rst_n), .key_in(key[2]), .key_valid(key_valid[2]),
      .key_ready(key_ready[2]), .ks_busy(ks_busy[2]), .ks_done(ks_done[2]),
      .rk_round(rk_round[2]), .rk_inv(rk_inv), .rk_data(rk_data[2]));

   typedef struct {
      int           d;
      logic [3:0]   r;
      logic         inv;
      logic [127:0] exp;
   } vec_t;

   localparam int NVEC = 20;
   vec_t vt [NVEC];

   localparam logic [127:0] T1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] T1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] T1_R9  = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] T1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [31:0] inv_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09),
              gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d),
              gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b),
              gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e)};
   endfunction

   // Expected value of an inner-round read with rk_inv=1 in the current build.
   function automatic logic [127:0] inv_exp(input logic [127:0] k);
`ifdef AES_KS_INV_EN
      return {inv_col(k[127:96]), inv_col(k[95:64]), inv_col(k[63:32]), inv_col(k[31:0])};
`else
      return k;
`endif
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input int d, input string name);
      check({name, "_ready"}, 128'(key_ready[d]), 128'd1);
      check({name, "_busy"},  128'(ks_busy[d]),   128'd0);
      check({name, "_done"},  128'(ks_done[d]),   128'd0);
      check({name, "_data"},  rk_data[d],         128'd0);
   endtask

   // Accept k on instance d, optionally holding key_valid (with a different key) through GEN,
   // and count edges from the accept edge to ks_done.
   task automatic run_key(input int d, input logic [255:0] k, input int exp_edges,
                          input bit hold, input string name);
      int n;
      key[d]       = k;
      key_valid[d] = 1'b1;
      step();
      if (hold) key[d] = ~k;
      else key_valid[d] = 1'b0;
      check({name, "_done_drop"}, 128'(ks_done[d]),   128'd0);
      check({name, "_busy_gen"},  128'(ks_busy[d]),   128'd1);
      check({name, "_ready_gen"}, 128'(key_ready[d]), 128'd0);
      n = 0;
      while (!ks_done[d] && n < 200) begin
         step();
         n++;
         if (n == 1) begin
            check({name, "_rd_zero_gen"}, rk_data[d],         128'd0);
            check({name, "_no_restart"},  128'(key_ready[d]), 128'd0);
         end
      end
      key_valid[d] = 1'b0;
      check({name, "_done_edges"}, 128'(n), 128'(exp_edges));
      check({name, "_busy_done"},  128'(ks_busy[d]),   128'd0);
      check({name, "_ready_done"}, 128'(key_ready[d]), 128'd1);
   endtask

   task automatic read_rk(input int d, input logic [3:0] r, input logic inv,
                          input logic [127:0] exp, input string name);
      rk_round[d] = r;
      rk_inv      = inv;
      step();
      check(name, rk_data[d], exp);
   endtask

   initial begin
      vt[0]  = '{0, 4'd0,  1'b0, T1_KEY};
      vt[1]  = '{0, 4'd1,  1'b0, T1_R1};
      vt[2]  = '{0, 4'd2,  1'b0, 128'hf2c295f27a96b9435935807a7359f67f};
      vt[3]  = '{0, 4'd9,  1'b0, T1_R9};
      vt[4]  = '{0, 4'd10, 1'b0, T1_R10};
      vt[5]  = '{0, 4'd11, 1'b0, 128'd0};
      vt[6]  = '{0, 4'd1,  1'b1, inv_exp(T1_R1)};
      vt[7]  = '{0, 4'd0,  1'b1, T1_KEY};
      vt[8]  = '{0, 4'd10, 1'b1, T1_R10};
      vt[9]  = '{0, 4'd9,  1'b1, inv_exp(T1_R9)};
      vt[10] = '{1, 4'd0,  1'b0, 128'h8e73b0f7da0e6452c810f32b809079e5};
      vt[11] = '{1, 4'd1,  1'b0, 128'h62f8ead2522c6b7bfe0c91f72402f5a5};
      vt[12] = '{1, 4'd12, 1'b0, 128'he98ba06f448c773c8ecc720401002202};
      vt[13] = '{1, 4'd13, 1'b0, 128'd0};
      vt[14] = '{2, 4'd0,  1'b0, 128'h603deb1015ca71be2b73aef0857d7781};
      vt[15] = '{2, 4'd1,  1'b0, 128'h1f352c073b6108d72d9810a30914dff4};
      vt[16] = '{2, 4'd2,  1'b0, 128'h9ba354118e6925afa51a8b5f2067fcde};
      vt[17] = '{2, 4'd3,  1'b0, 128'ha8b09c1a93d194cdbe49846eb75d5b9a};
      vt[18] = '{2, 4'd14, 1'b0, 128'hfe4890d1e6188d0b046df344706c631e};
      vt[19] = '{2, 4'd15, 1'b0, 128'd0};

      rst_n  = 1'b0;
      rk_inv = 1'b0;
      for (int d = 0; d < 3; d++) begin
         key[d]       = '0;
         key_valid[d] = 1'b0;
         rk_round[d]  = 4'd0;
      end
      step();
      step();
      rst_n = 1'b1;
      step();

      check_idle_outputs(0, "rst128");
      check_idle_outputs(1, "rst192");
      check_idle_outputs(2, "rst256");
      read_rk(0, 4'd0, 1'b0, 128'd0, "rd_before_done");

      // Reset in the middle of an expansion aborts it.
      key[0]       = {128'd0, T1_KEY};
      key_valid[0] = 1'b1;
      step();
      key_valid[0] = 1'b0;
      repeat (19) step();
      rst_n = 1'b0;
      #1;
      check_idle_outputs(0, "midrst");
      #2;
      rst_n = 1'b1;
      step();
      check("midrst_no_done", 128'(ks_done[0]), 128'd0);

      run_key(0, {128'd0, T1_KEY}, 40, 1'b0, "t1");
      run_key(1, {64'd0, 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b}, 46, 1'b0, "t2");
      run_key(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
              52, 1'b0, "t3");

      for (int i = 0; i < NVEC; i++) begin
         read_rk(vt[i].d, vt[i].r, vt[i].inv, vt[i].exp, $sformatf("vec%0d", i));
      end

      // New key accepted in DONE with key_valid held through the whole expansion.
      read_rk(0, 4'd1, 1'b0, T1_R1, "t4_before");
      run_key(0, {128'd0, 128'h000102030405060708090a0b0c0d0e0f}, 40, 1'b1, "t4");
      read_rk(0, 4'd1,  1'b0, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe, "t4_r1");
      read_rk(0, 4'd10, 1'b0, 128'h13111d7fe3944a17f307a78b4d2b30c5, "t4_r10");
      read_rk(0, 4'd0,  1'b0, 128'h000102030405060708090a0b0c0d0e0f, "t4_r0");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
